multi_core_perf_csr: RTL
========================

MULTI_CORE_PERF_CSR -- requirements
Module: multi_core_perf_csr

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of cores whose activity bits are reported (1..32).
REQ-002 SHALL have ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  register request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  8  byte address.
- req_wdata_i  in  32  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  32  read data.
- rsp_error_o  out  1  access error.
- total_instructions_i  in  32  free-running system counter.
- total_cycles_i  in  32  free-running system counter.
- cache_miss_count_i  in  32  free-running system counter.
- sys_status_i  in  32  system status.
- core_active_i  in  NUM_CORES  per-core active flags.
- sys_config_o  out  32  system configuration, drives the system's config input.
- irq_o  out  1  threshold interrupt.

Function
REQ-003 Handshake FSM SHALL have states IDLE and RESP. req_ready_o = (state==IDLE).
- IDLE→RESP on req_valid_i&req_ready_o; access executes on that edge.
- RESP→IDLE on rsp_valid_o&rsp_ready_i.
- rsp_valid_o = (state==RESP).
- rsp_rdata_o and rsp_error_o held stable throughout RESP.
- Latency accept→rsp_valid_o = 1 cycle.
REQ-004 Address map SHALL be:
- 0x00 CONFIG RW → sys_config_o.
- 0x04 STATUS RO, live sys_status_i.
- 0x08 CTRL WO: bit0 snapshot, bit1 clear-extensions; reads 0.
- 0x0C CORE_ACTIVE RO, zero-extended.
- 0x10/0x14 INSTR_LO/HI snapshot.
- 0x18/0x1C CYC_LO/HI snapshot.
- 0x20/0x24 MISS_LO/HI snapshot.
- 0x28 IRQ_EN RW bit0.
- 0x2C IRQ_STAT bit0, write-1-to-clear.
- 0x30/0x34 THRESH_LO/HI RW.
REQ-005 Unmapped address, req_addr_i[1:0]≠0, write to an RO register, or read of CTRL SHALL give rsp_error_o=1, rsp_rdata_o=0, and no state change.
REQ-006 For each of the 3 counter inputs, the block SHALL register the previous sample; when input < previous, the 32-bit HI extension increments by 1 modulo 2^32.
REQ-007 CTRL bit1 write SHALL zero all HI extensions on the access edge; clear wins over a same-cycle wrap increment; previous-sample tracking continues unaffected.
REQ-008 CTRL bit0 write SHALL atomically latch {HI_next, live input} for all 3 counters into snapshot registers on the access edge (HI_next includes same-cycle wrap/clear).
- If bit0 and bit1 are written together, the snapshot captures HI=0.
REQ-009 Every cycle, the 64-bit value {INSTR_HI, total_instructions_i} >= {THRESH_HI, THRESH_LO} (unsigned) with IRQ_EN=1 SHALL set IRQ_STAT on the next edge.
- A same-cycle W1C loses to a set.
REQ-010 irq_o SHALL be a registered output equal to IRQ_STAT & IRQ_EN; 1 cycle after IRQ_STAT changes.
REQ-011 Writes SHALL take effect on the access edge; a read in RESP returns the value present at accept.
REQ-012 req_valid_i while in RESP SHALL be ignored (not accepted) until IDLE.

Reset
REQ-013 rst_i high SHALL asynchronously force:
- state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0;
- sys_config_o=0, irq_o=0;
- all HI, snapshot, previous-sample, THRESH, IRQ_EN and IRQ_STAT registers = 0.
REQ-014 Reset asserted during RESP SHALL drop the pending response with no completion; the first post-reset access behaves normally.

Verification
REQ-015 Write 0x00=0xA5A5_0001, then read 0x00 → sys_config_o=0xA5A50001 one edge after accept; read rsp_rdata_o=0xA5A50001, rsp_error_o=0, 1-cycle latency.
REQ-016 total_instructions_i 0xFFFF_FFFE → 0x0000_0003, then CTRL=0x1 → INSTR_HI=1, INSTR_LO=3.
REQ-017 THRESH={0,100}, IRQ_EN=1, instructions reach 100 → IRQ_STAT=1 next edge, irq_o=1 one cycle later; W1C 0x2C=1 with instructions<100 → irq_o=0.
REQ-018 Read 0x40, read 0x06, write 0x04 → each rsp_error_o=1, rdata=0, CONFIG unchanged.
REQ-019 Hold rsp_ready_i=0 for 5 cycles in RESP → rsp_valid_o and rdata stable, req_ready_o=0; assert rst_i mid-RESP → rsp_valid_o=0, req_ready_o=1 immediately.
REQ-020 Wrap and CTRL=0x3 on the same cycle → snapshot HI=0, live HI=0.

Source files
------------

// File: rtl/multi_core_perf_csr.sv
`default_nettype none
// ============================================================================
// Module      : multi_core_perf_csr
// Description : Register block exposing 64-bit extended system counters,
//               atomic snapshots, configuration and a threshold interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_core_perf_csr #(
    parameter int NUM_CORES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [7:0]           req_addr_i,
    input  logic [31:0]          req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    input  logic [31:0]          total_instructions_i,
    input  logic [31:0]          total_cycles_i,
    input  logic [31:0]          cache_miss_count_i,
    input  logic [31:0]          sys_status_i,
    input  logic [NUM_CORES-1:0] core_active_i,
    output logic [31:0]          sys_config_o,
    output logic                 irq_o
);

    localparam logic [7:0] c_ADDR_CONFIG    = 8'h00;
    localparam logic [7:0] c_ADDR_STATUS    = 8'h04;
    localparam logic [7:0] c_ADDR_CTRL      = 8'h08;
    localparam logic [7:0] c_ADDR_CORE      = 8'h0C;
    localparam logic [7:0] c_ADDR_INSTR_LO  = 8'h10;
    localparam logic [7:0] c_ADDR_INSTR_HI  = 8'h14;
    localparam logic [7:0] c_ADDR_CYC_LO    = 8'h18;
    localparam logic [7:0] c_ADDR_CYC_HI    = 8'h1C;
    localparam logic [7:0] c_ADDR_MISS_LO   = 8'h20;
    localparam logic [7:0] c_ADDR_MISS_HI   = 8'h24;
    localparam logic [7:0] c_ADDR_IRQ_EN    = 8'h28;
    localparam logic [7:0] c_ADDR_IRQ_STAT  = 8'h2C;
    localparam logic [7:0] c_ADDR_THRESH_LO = 8'h30;
    localparam logic [7:0] c_ADDR_THRESH_HI = 8'h34;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_config;
    logic        r_irq_en;
    logic        r_irq_stat;
    logic        r_irq;
    logic [31:0] r_thresh_lo;
    logic [31:0] r_thresh_hi;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_error;
    logic [31:0] r_prev    [3];
    logic [31:0] r_hi      [3];
    logic [31:0] r_snap_lo [3];
    logic [31:0] r_snap_hi [3];

    logic [31:0] w_cnt_in  [3];
    logic [31:0] w_hi_next [3];
    logic [31:0] w_core_ext;
    logic [31:0] w_rd_data;
    logic        w_mapped;
    logic        w_readable;
    logic        w_writable;
    logic        w_err;
    logic        w_accept;
    logic        w_wr_en;
    logic        w_snapshot;
    logic        w_clear;
    logic        w_irq_w1c;
    logic        w_irq_hit;

    assign req_ready_o  = (r_state == ST_IDLE);
    assign rsp_valid_o  = (r_state == ST_RESP);
    assign rsp_rdata_o  = r_rsp_rdata;
    assign rsp_error_o  = r_rsp_error;
    assign sys_config_o = r_config;
    assign irq_o        = r_irq;

    assign w_accept = req_valid_i & req_ready_o;
    assign w_cnt_in[0] = total_instructions_i;
    assign w_cnt_in[1] = total_cycles_i;
    assign w_cnt_in[2] = cache_miss_count_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_next = ST_RESP;
            ST_RESP: if (rsp_ready_i) w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_core_ext = '0;
        w_core_ext[NUM_CORES-1:0] = core_active_i;
    end

    // Address decode: read value plus access legality for the current request
    always_comb begin
        w_rd_data  = '0;
        w_mapped   = 1'b1;
        w_readable = 1'b1;
        w_writable = 1'b0;
        case (req_addr_i)
            c_ADDR_CONFIG:    begin w_rd_data = r_config; w_writable = 1'b1; end
            c_ADDR_STATUS:    w_rd_data = sys_status_i;
            c_ADDR_CTRL:      begin w_readable = 1'b0; w_writable = 1'b1; end
            c_ADDR_CORE:      w_rd_data = w_core_ext;
            c_ADDR_INSTR_LO:  w_rd_data = r_snap_lo[0];
            c_ADDR_INSTR_HI:  w_rd_data = r_snap_hi[0];
            c_ADDR_CYC_LO:    w_rd_data = r_snap_lo[1];
            c_ADDR_CYC_HI:    w_rd_data = r_snap_hi[1];
            c_ADDR_MISS_LO:   w_rd_data = r_snap_lo[2];
            c_ADDR_MISS_HI:   w_rd_data = r_snap_hi[2];
            c_ADDR_IRQ_EN:    begin w_rd_data = {31'b0, r_irq_en}; w_writable = 1'b1; end
            c_ADDR_IRQ_STAT:  begin w_rd_data = {31'b0, r_irq_stat}; w_writable = 1'b1; end
            c_ADDR_THRESH_LO: begin w_rd_data = r_thresh_lo; w_writable = 1'b1; end
            c_ADDR_THRESH_HI: begin w_rd_data = r_thresh_hi; w_writable = 1'b1; end
            default:          w_mapped = 1'b0;
        endcase
    end

    assign w_err = ~w_mapped | (req_addr_i[1:0] != 2'b00)
                 | (req_write_i & ~w_writable) | (~req_write_i & ~w_readable);
    assign w_wr_en    = w_accept & req_write_i & ~w_err;
    assign w_snapshot = w_wr_en & (req_addr_i == c_ADDR_CTRL) & req_wdata_i[0];
    assign w_clear    = w_wr_en & (req_addr_i == c_ADDR_CTRL) & req_wdata_i[1];
    assign w_irq_w1c  = w_wr_en & (req_addr_i == c_ADDR_IRQ_STAT) & req_wdata_i[0];
    assign w_irq_hit  = r_irq_en
                      & ({r_hi[0], total_instructions_i} >= {r_thresh_hi, r_thresh_lo});

    // Clear has priority over a wrap detected on the same edge
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_hi_next[k] = w_clear ? 32'd0
                         : r_hi[k] + {31'b0, (w_cnt_in[k] < r_prev[k])};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 3; k++) begin
                r_prev[k]    <= '0;
                r_hi[k]      <= '0;
                r_snap_lo[k] <= '0;
                r_snap_hi[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                r_prev[k] <= w_cnt_in[k];
                r_hi[k]   <= w_hi_next[k];
                if (w_snapshot) begin
                    r_snap_lo[k] <= w_cnt_in[k];
                    r_snap_hi[k] <= w_hi_next[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_config    <= '0;
            r_irq_en    <= 1'b0;
            r_irq_stat  <= 1'b0;
            r_irq       <= 1'b0;
            r_thresh_lo <= '0;
            r_thresh_hi <= '0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            if (w_wr_en && req_addr_i == c_ADDR_CONFIG)    r_config    <= req_wdata_i;
            if (w_wr_en && req_addr_i == c_ADDR_IRQ_EN)    r_irq_en    <= req_wdata_i[0];
            if (w_wr_en && req_addr_i == c_ADDR_THRESH_LO) r_thresh_lo <= req_wdata_i;
            if (w_wr_en && req_addr_i == c_ADDR_THRESH_HI) r_thresh_hi <= req_wdata_i;
            // A threshold hit outranks a same-cycle write-1-to-clear
            if (w_irq_hit)      r_irq_stat <= 1'b1;
            else if (w_irq_w1c) r_irq_stat <= 1'b0;
            r_irq <= r_irq_stat & r_irq_en;
            if (w_accept) begin
                r_rsp_rdata <= (w_err | req_write_i) ? 32'd0 : w_rd_data;
                r_rsp_error <= w_err;
            end
        end
    end

endmodule
`default_nettype wire
